// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encodings, common to transmitter and receiver.
package uart_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned BAUD      = 115_200;
  localparam int unsigned BAUD_TICK = CLK_HZ / BAUD;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 2;
  localparam int unsigned STATE_W   = 3;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] START = 3'd1;
  localparam logic [STATE_W-1:0] DATA  = 3'd2;
  localparam logic [STATE_W-1:0] STOP1 = 3'd3;
  localparam logic [STATE_W-1:0] STOP2 = 3'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with registered count, full and empty flags.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_wr;
  logic          do_rd;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N2 frames shifted LSB-first from an internal FIFO, back-to-back while data is queued.
module uart_tx #(
  parameter int unsigned BAUD_TICK  = uart_pkg::BAUD_TICK,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_wr,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy,
  output logic       tx,
  output logic [2:0] state
);

  import uart_pkg::*;

  localparam int unsigned CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_TICK - 1);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [7:0]         shift_q;
  logic [7:0]         shift_d;
  logic [2:0]         bit_idx_q;
  logic [2:0]         bit_idx_d;
  logic               tx_q;
  logic               tx_d;
  logic               busy_q;
  logic               busy_d;
  logic               overflow_q;
  logic               overflow_d;
  logic               bit_end;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [7:0]         fifo_head;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (data_wr),
    .wr_data (data_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Next state, shifter and line level; tx lags state by one clock so it is always a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CNT_W'(1);
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    fifo_pop   = 1'b0;
    tx_d       = 1'b1;
    busy_d     = (state_q != IDLE) || !fifo_empty;
    overflow_d = data_wr && fifo_full;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) state_d = STOP2;
      end
      STOP2: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance plus a 4-deep FIFO instance, each watched by a line decoder.
module tb_uart_tx;

  localparam int BT    = 434;
  localparam int FRAME = 11 * BT;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         t0;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       full, ov, busy, tx;
  logic [2:0] state;
  logic [7:0] din4 = 8'h00;
  logic       wr4 = 1'b0;
  logic       full4, ov4, busy4, tx4;
  logic [2:0] state4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  rx_t rxq0[$];
  rx_t rxq1[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx dut (
    .clk(clk), .rst(rst), .data_in(din), .data_wr(wr), .fifo_full(full),
    .overflow(ov), .busy(busy), .tx(tx), .state(state)
  );

  uart_tx #(.BAUD_TICK(434), .FIFO_DEPTH(4), .FIFO_AW(2)) dut4 (
    .clk(clk), .rst(rst), .data_in(din4), .data_wr(wr4), .fifo_full(full4),
    .overflow(ov4), .busy(busy4), .tx(tx4), .state(state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Receiver model: samples each bit centre, flags bad start/stop, drops frames cut by reset.
  task automatic rx_monitor(input int d);
    rx_t  r;
    logic line;
    bit   aborted;
    int   k;
    forever begin
      @(posedge clk);
      #1;
      line = (d == 0) ? tx : tx4;
      if (!rst && line === 1'b0) begin
        r.t0 = cyc; r.data = 8'h00; r.ferr = 1'b0; aborted = 1'b0;
        for (int i = 1; i <= 217 + 10 * BT && !aborted; i++) begin
          @(posedge clk);
          if (rst) aborted = 1'b1;
          #1;
          line = (d == 0) ? tx : tx4;
          if (!aborted && i >= 217 && ((i - 217) % BT) == 0) begin
            k = (i - 217) / BT;
            if (k == 0) begin
              if (line !== 1'b0) r.ferr = 1'b1;
            end else if (k <= 8) begin
              r.data[k-1] = line;
            end else if (line !== 1'b1) begin
              r.ferr = 1'b1;
            end
          end
        end
        if (!aborted) begin
          if (d == 0) rxq0.push_back(r);
          else rxq1.push_back(r);
        end
      end
    end
  endtask

  initial rx_monitor(0);
  initial rx_monitor(1);

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", ov); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tx4 !== 1'b1 || busy4 !== 1'b0 || state4 !== 3'd0) begin
      n_fail++; $display("FAIL reset_dut4: tx=%b busy=%b state=%0d expected 1 0 0", tx4, busy4, state4);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int wr_cyc, t0, errs;
    rxq0.delete();
    din = 8'h55; wr = 1'b1;
    tick();
    wr_cyc = cyc; wr = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_early: got %b expected 1", tx); end
    tick();
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL single_start_latency: tx=%b at +%0d expected 0 at +2", tx, cyc - wr_cyc); end
    t0 = cyc;
    errs = 0;
    for (int i = 1; i < FRAME; i++) begin
      tick();
      if (tx !== frame_bit(8'h55, i / BT)) errs++;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL single_waveform: %0d wrong cycles expected 0", errs); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b at +%0d expected 0 at +%0d", busy, cyc - t0, FRAME); end
    n_checks++; if (state !== 3'd0 || tx !== 1'b1) begin n_fail++; $display("FAIL single_idle: state=%0d tx=%b expected 0 1", state, tx); end
    n_checks++; if (rxq0.size() != 1) begin
      n_fail++; $display("FAIL single_rx_count: got %0d expected 1", rxq0.size());
    end else if (rxq0[0].data !== 8'h55 || rxq0[0].ferr !== 1'b0) begin
      n_fail++; $display("FAIL single_rx_data: got %h ferr=%b expected 55 ferr=0", rxq0[0].data, rxq0[0].ferr);
    end
  endtask

  task automatic test_back_to_back();
    int wr_cyc;
    rxq0.delete();
    din = 8'hA5; wr = 1'b1;
    tick();
    wr_cyc = cyc; din = 8'h3C;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 3 * FRAME && busy !== 1'b0; i++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: busy=%b expected 0", busy); end
    n_checks++; if (rxq0.size() != 2) begin
      n_fail++; $display("FAIL b2b_rx_count: got %0d expected 2", rxq0.size());
    end else begin
      n_checks++; if (rxq0[0].data !== 8'hA5 || rxq0[1].data !== 8'h3C || rxq0[0].ferr || rxq0[1].ferr) begin
        n_fail++; $display("FAIL b2b_data: got %h %h expected a5 3c", rxq0[0].data, rxq0[1].data);
      end
      n_checks++; if (rxq0[0].t0 - wr_cyc != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", rxq0[0].t0 - wr_cyc); end
      n_checks++; if (rxq0[1].t0 - rxq0[0].t0 != FRAME) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", rxq0[1].t0 - rxq0[0].t0, FRAME); end
      n_checks++; if (cyc - rxq0[0].t0 != 2 * FRAME) begin n_fail++; $display("FAIL b2b_busy_time: got %0d expected %0d", cyc - rxq0[0].t0, 2 * FRAME); end
    end
  endtask

  task automatic test_overflow();
    rxq1.delete();
    for (int i = 0; i < 7; i++) begin
      din4 = 8'(i + 1); wr4 = 1'b1;
      tick();
      n_checks++; if (ov4 !== (i >= 5)) begin n_fail++; $display("FAIL ovf_pulse_%0d: got %b expected %b", i, ov4, (i >= 5)); end
      n_checks++; if (full4 !== (i >= 4)) begin n_fail++; $display("FAIL ovf_full_%0d: got %b expected %b", i, full4, (i >= 4)); end
    end
    wr4 = 1'b0;
    tick();
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end: got %b expected 0", ov4); end
    for (int i = 0; i < 6 * FRAME && busy4 !== 1'b0; i++) tick();
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout: busy=%b expected 0", busy4); end
    n_checks++; if (rxq1.size() != 5) begin
      n_fail++; $display("FAIL ovf_rx_count: got %0d expected 5", rxq1.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (rxq1[i].data !== 8'(i + 1) || rxq1[i].ferr !== 1'b0) begin
          n_fail++; $display("FAIL ovf_rx_%0d: got %h ferr=%b expected %h ferr=0", i, rxq1[i].data, rxq1[i].ferr, 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_cyc, t0, bad;
    rxq0.delete();
    din = 8'hFF; wr = 1'b1;
    tick();
    wr_cyc = cyc; din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    wr = 1'b0;
    t0 = wr_cyc + 2;
    for (int i = 0; i < 3000 && cyc < t0 + 4 * BT + 200; i++) tick();
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL rstmid_in_data: state=%0d expected 2", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", state); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < FRAME + 500; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles expected 0", bad); end
    n_checks++; if (rxq0.size() != 0) begin n_fail++; $display("FAIL rstmid_frames: got %0d expected 0", rxq0.size()); end
  endtask

  task automatic test_loopback();
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'h81;
    rxq0.delete();
    for (int i = 0; i < 4; i++) begin
      din = lb[i]; wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    for (int i = 0; i < 5 * FRAME && busy !== 1'b0; i++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_timeout: busy=%b expected 0", busy); end
    n_checks++; if (rxq0.size() != 4) begin
      n_fail++; $display("FAIL loop_valid_count: got %0d expected 4", rxq0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (rxq0[i].data !== lb[i]) begin n_fail++; $display("FAIL loop_data_%0d: got %h expected %h", i, rxq0[i].data, lb[i]); end
        n_checks++; if (rxq0[i].ferr !== 1'b0) begin n_fail++; $display("FAIL loop_frame_error_%0d: got %b expected 0", i, rxq0[i].ferr); end
      end
      n_checks++; if (rxq0[3].t0 - rxq0[0].t0 != 3 * FRAME) begin
        n_fail++; $display("FAIL loop_spacing: got %0d expected %0d", rxq0[3].t0 - rxq0[0].t0, 3 * FRAME);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
